// File: rtl/gerador_freq_prog.sv
// Programmable multi-channel square-wave generator with per-channel glitch-free
// half-period reload, toggle strobes and rising-edge strobes.
module gerador_freq_prog #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DIV_W = 28,
   parameter logic [N_CH*DIV_W-1:0] DIV_INIT =
      {28'd150000000, 28'd50000000, 28'd25000000, 28'd12500000},
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [N_CH-1:0]   enable,
   input  logic              sync_clr,
   input  logic              load,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [DIV_W-1:0]  load_div,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   rise
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q    [N_CH];
   logic [DIV_W-1:0] cnt_d    [N_CH];
   logic [DIV_W-1:0] hp_q     [N_CH];
   logic [DIV_W-1:0] hp_d     [N_CH];
   logic [DIV_W-1:0] hp_nxt_q [N_CH];
   logic [DIV_W-1:0] hp_nxt_d [N_CH];
   logic [N_CH-1:0]  clk_q, clk_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  sel;
   logic [DIV_W-1:0] load_val;

   // A zero half-period would never reach terminal count; clamp to 1.
   assign load_val = (load_div == '0) ? ONE : load_div;

   always_comb begin
      clk_d  = clk_q;
      tick_d = '0;
      rise_d = '0;
      sel    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         // Indices >= N_CH never match any channel, so they are dropped here.
         sel[i]      = load && (load_ch == CH_W'(i));
         cnt_d[i]    = cnt_q[i];
         hp_d[i]     = hp_q[i];
         hp_nxt_d[i] = sel[i] ? load_val : hp_nxt_q[i];
         if (sync_clr) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
            hp_d[i]  = hp_nxt_d[i];
         end else if (!enable[i]) begin
            if (sel[i]) hp_d[i] = load_val;
         end else if (cnt_q[i] == hp_q[i] - ONE) begin
            cnt_d[i]  = '0;
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = 1'b1;
            rise_d[i] = ~clk_q[i];
            hp_d[i]   = hp_nxt_d[i];
         end else begin
            cnt_d[i] = cnt_q[i] + ONE;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= '0;
            hp_q[i]     <= DIV_INIT[i*DIV_W +: DIV_W];
            hp_nxt_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
         end
         clk_q  <= '0;
         tick_q <= '0;
         rise_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         hp_q     <= hp_d;
         hp_nxt_q <= hp_nxt_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         rise_q   <= rise_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign rise    = rise_q;

endmodule

// File: tb/tb_gerador_freq_prog.sv
// Bench for gerador_freq_prog: constant vector table, hand-written corner
// sequences and a queue scoreboard fed by a cycle model.
`timescale 1ns/100ps
module tb_gerador_freq_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] enable = 4'hF;
   logic       sync_clr = 1'b0, load = 1'b0;
   logic [1:0] load_ch = 2'd0;
   logic [7:0] load_div = 8'd0;
   logic [3:0] clk_out, tick, rise;

   logic [2:0] en2 = 3'b111;
   logic       clr2 = 1'b0, ld2 = 1'b0;
   logic [1:0] ch2 = 2'd0;
   logic [7:0] div2 = 8'd0;
   logic [2:0] co2, tk2, rs2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gerador_freq_prog #(.N_CH(4), .DIV_W(8), .DIV_INIT({8'd4, 8'd3, 8'd2, 8'd1})) dut (
      .clk_in(clk), .rst(rst), .enable(enable), .sync_clr(sync_clr), .load(load),
      .load_ch(load_ch), .load_div(load_div), .clk_out(clk_out), .tick(tick), .rise(rise)
   );

   gerador_freq_prog #(.N_CH(3), .DIV_W(8), .DIV_INIT({8'd3, 8'd2, 8'd1})) dut2 (
      .clk_in(clk), .rst(rst), .enable(en2), .sync_clr(clr2), .load(ld2),
      .load_ch(ch2), .load_div(div2), .clk_out(co2), .tick(tk2), .rise(rs2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of the four main-DUT channels
   int         m_cnt [4];
   int         m_hp  [4];
   int         m_hpn [4];
   logic [3:0] m_clk, m_tick, m_rise;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0;
         m_hp[i]  = i + 1;
         m_hpn[i] = i + 1;
      end
      m_clk = '0; m_tick = '0; m_rise = '0;
   endtask

   task automatic model_step(input logic [3:0] en, input logic clr, input logic ld,
                             input logic [1:0] ch, input logic [7:0] dv);
      int nv;
      nv = (dv == 8'd0) ? 1 : int'(dv);
      for (int i = 0; i < 4; i++) begin
         bit s;
         s = ld && (int'(ch) == i);
         if (s) m_hpn[i] = nv;
         m_tick[i] = 1'b0;
         m_rise[i] = 1'b0;
         if (clr) begin
            m_cnt[i] = 0; m_clk[i] = 1'b0; m_hp[i] = m_hpn[i];
         end else if (!en[i]) begin
            if (s) m_hp[i] = nv;
         end else if (m_cnt[i] + 1 == m_hp[i]) begin
            m_cnt[i] = 0; m_clk[i] = ~m_clk[i]; m_tick[i] = 1'b1;
            m_rise[i] = m_clk[i]; m_hp[i] = m_hpn[i];
         end else begin
            m_cnt[i]++;
         end
      end
   endtask

   logic [11:0] exp_q [$];

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         check("scoreboard {rise,tick,clk_out}", {rise, tick, clk_out}, e);
      end
   end

   task automatic step(input logic [3:0] en, input logic clr, input logic ld,
                       input logic [1:0] ch, input logic [7:0] dv);
      @(negedge clk);
      enable = en; sync_clr = clr; load = ld; load_ch = ch; load_div = dv;
      model_step(en, clr, ld, ch, dv);
      exp_q.push_back({m_rise, m_tick, m_clk});
   endtask

   task automatic idle();
      step(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [3:0] en;
      logic       clr;
      logic [3:0] c, t, r;
   } vec_t;
   vec_t tbl [14];

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step(tbl[i].en, tbl[i].clr, 1'b0, 2'd0, 8'd0);
         settle();
         check($sformatf("table[%0d] clk_out", i), clk_out, tbl[i].c);
         check($sformatf("table[%0d] tick", i), tick, tbl[i].t);
         check($sformatf("table[%0d] rise", i), rise, tbl[i].r);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rcnt [4];
      logic [2:0] exp2 [6];

      // Power-up sequence for half-periods {1,2,3,4} on ch0..ch3
      tbl[0]  = '{4'hF, 1'b0, 4'b0001, 4'b0001, 4'b0001};
      tbl[1]  = '{4'hF, 1'b0, 4'b0010, 4'b0011, 4'b0010};
      tbl[2]  = '{4'hF, 1'b0, 4'b0111, 4'b0101, 4'b0101};
      tbl[3]  = '{4'hF, 1'b0, 4'b1100, 4'b1011, 4'b1000};
      tbl[4]  = '{4'hF, 1'b0, 4'b1101, 4'b0001, 4'b0001};
      tbl[5]  = '{4'hF, 1'b0, 4'b1010, 4'b0111, 4'b0010};
      tbl[6]  = '{4'hF, 1'b0, 4'b1011, 4'b0001, 4'b0001};
      tbl[7]  = '{4'hF, 1'b0, 4'b0000, 4'b1011, 4'b0000};
      tbl[8]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 4'b0000};
      tbl[9]  = tbl[0];
      tbl[10] = tbl[1];
      tbl[11] = tbl[2];
      tbl[12] = '{4'h0, 1'b0, 4'b0111, 4'b0000, 4'b0000};
      tbl[13] = tbl[3];

      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset clk_out", clk_out, 4'h0);
      check("reset tick", tick, 4'h0);
      check("reset rise", rise, 4'h0);
      rst = 1'b0;

      run_table(0, 13);

      // ch1 frozen for 7 cycles after one count, then finishes its half-period
      step(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      idle();
      for (int k = 0; k < 7; k++) begin
         step(4'b1101, 1'b0, 1'b0, 2'd0, 8'd0);
         settle();
         check("freeze clk_out[1]", clk_out[1], 1'b0);
         check("freeze tick[1]", tick[1], 1'b0);
      end
      idle();
      settle();
      check("resume clk_out[1]", clk_out[1], 1'b1);
      check("resume rise[1]", rise[1], 1'b1);

      // ch2 reload 3 -> 5 in mid half-period: toggles at edges 3, 8, 13
      step(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      for (int k = 1; k <= 15; k++) begin
         step(4'hF, 1'b0, (k == 2), 2'd2, 8'd5);
         settle();
         check($sformatf("reload tick[2] edge %0d", k), tick[2], (k == 3 || k == 8 || k == 13));
      end

      // restore ch2 to 3 with load+sync_clr, then phase alignment over 48 cycles
      step(4'hF, 1'b1, 1'b1, 2'd2, 8'd3);
      settle();
      check("sync_clr clk_out", clk_out, 4'h0);
      for (int i = 0; i < 4; i++) rcnt[i] = 0;
      for (int k = 1; k <= 48; k++) begin
         idle();
         settle();
         for (int i = 0; i < 4; i++) if (rise[i]) rcnt[i]++;
         if (k % 24 == 0) begin
            check($sformatf("lcm clk_out[3:1] edge %0d", k), clk_out[3:1], 3'b000);
            check($sformatf("lcm tick[3:1] edge %0d", k), tick[3:1], 3'b111);
         end
      end
      check("rise count ch0", rcnt[0], 24);
      check("rise count ch1", rcnt[1], 12);
      check("rise count ch2", rcnt[2], 8);
      check("rise count ch3", rcnt[3], 6);

      // load_div=0 is stored as 1: ch3 toggles every cycle after sync_clr
      step(4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
      step(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      for (int k = 1; k <= 6; k++) begin
         idle();
         settle();
         check($sformatf("hp1 tick[3] edge %0d", k), tick[3], 1'b1);
         check($sformatf("hp1 clk_out[3] edge %0d", k), clk_out[3], (k % 2 == 1));
      end

      // 1 ns reset pulse between edges: outputs clear at once, then power-up replay
      rst = 1'b1;
      #1;
      check("async rst clk_out", clk_out, 4'h0);
      check("async rst tick", tick, 4'h0);
      check("async rst rise", rise, 4'h0);
      rst = 1'b0;
      model_reset();
      run_table(0, 7);

      for (int k = 0; k < 300; k++) begin
         step(4'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
              2'($urandom), 8'($urandom_range(0, 6)));
      end
      settle();

      // N_CH=3 instance: load to index 3 must not touch any channel
      @(negedge clk);
      ld2 = 1'b1; ch2 = 2'd3; div2 = 8'd7;
      @(negedge clk);
      ld2 = 1'b0; clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      exp2 = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b101, 3'b010};
      for (int k = 0; k < 6; k++) begin
         settle();
         check($sformatf("bad index clk_out edge %0d", k + 1), co2, exp2[k]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
